mbutton_events: RTL
===================

Name: mbutton_events

Overview:
- Downstream consumer of the muxed-pushbutton demux/debounce stage. Takes its 6-bit debounced `buttons` vector.
- Converts each button into single-cycle event pulses for the application FSMs: press, release, long-press and auto-repeat, plus a registered held level.
- Timing is driven by an external tick from the timing block, so thresholds are counted in ticks, not clocks.

Parameters:
- NOB, 6, number of buttons (matches the debounced vector width).
- CNT_W, 10, width of each per-button tick counter.
- LONG_TICKS, 500, ticks a button must be held before long_press fires (range 2..2^CNT_W-1).
- REPEAT_TICKS, 100, ticks between successive repeat pulses after long_press (range 1..2^CNT_W-1).
- REPEAT_EN, 1, 1 = auto-repeat enabled; 0 = no repeat pulses after long_press.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous reset, active-high
- tick  input  1  one-clk-wide timebase pulse (e.g. 1 ms), synchronous to clk
- buttons  input  NOB  debounced button levels, already synchronous to clk, 1 = pressed
- held  output  NOB  registered copy of buttons
- press  output  NOB  one-clk pulse on press
- release  output  NOB  one-clk pulse on release
- long_press  output  NOB  one-clk pulse when hold reaches LONG_TICKS
- repeat  output  NOB  one-clk pulse every REPEAT_TICKS after long_press
- any_event  output  1  OR of all press/release/long_press/repeat bits, same cycle

Behaviour:
- Reset: asynchronous, active-high. On assertion all outputs, the previous-level register, all FSM states and all counters clear to 0 immediately and stay cleared until reset deasserts. Events resume from the first clk edge after deassertion.
- Buttons already held when reset releases produce a press pulse, because the previous-level register resets to 0.
- All outputs are registered. Latency is one clk from the edge at which the input change or tick is sampled to the output pulse.
- Each button i has an independent FSM with a CNT_W-bit counter:
  - IDLE:
    - buttons[i]=1 sampled -> press[i]=1 next cycle; go to HOLD; counter=0.
  - HOLD:
    - Each tick with counter<LONG_TICKS-1 -> counter+1.
    - A tick with counter==LONG_TICKS-1 -> long_press[i] pulse; go to REPEAT; counter=0.
  - REPEAT:
    - Each tick with counter<REPEAT_TICKS-1 -> counter+1.
    - A tick with counter==REPEAT_TICKS-1 -> repeat[i] pulse (only if REPEAT_EN=1); counter=0.
    - With REPEAT_EN=0, REPEAT is parked: the counter holds and no pulses are issued.
  - Any state with buttons[i]=0 sampled -> release[i] pulse if the previous sampled level was 1; go to IDLE; counter=0.
- Simultaneous events:
  - Release in the same cycle as a terminal tick: release wins. No long_press or repeat pulse is issued.
  - Press in the same cycle as a tick: the tick is not counted. Counting starts from the next tick.
- At most one of press/release/long_press/repeat is high per bit per cycle. Different bits are fully independent and may pulse in the same cycle.
- First long_press occurs exactly LONG_TICKS ticks after press. Later repeats occur every REPEAT_TICKS ticks.
- A release followed by a re-press restarts HOLD from counter 0; no state is carried over.
- Counters never wrap: they are cleared at every terminal count and on every release.
- held = buttons delayed one clk.

Test Plan (LONG_TICKS=5, REPEAT_TICKS=3, tick every 4 clks):
- Reset active, buttons=6'h3F -> all outputs 0. After reset release: press=6'h3F for exactly 1 clk; held=6'h3F.
- buttons[2] held for 20 ticks -> press[2] once; long_press[2] on the 5th tick after press; repeat[2] on ticks 8, 11, 14, 17, 20; release[2] one clk after release; no other bits pulse.
- buttons[0] released in the same cycle as its 5th tick -> release[0]=1 and long_press[0]=0; FSM returns to IDLE.
- REPEAT_EN=0, buttons[1] held for 15 ticks -> exactly one long_press[1] and zero repeat pulses.
- Reset asserted mid-HOLD (tick 3) for 2 clks, button still held -> outputs clear immediately and asynchronously; after release, a fresh press[i]; long_press 5 ticks later, not 2.
- buttons[3] pressed 2 ticks, released, re-pressed -> second press pulse; long_press[3] 5 ticks after the second press; any_event tracks every pulse.

Source files
------------

// File: rtl/mbutton_events.sv
// mbutton_events: turns the debounced pushbutton vector into per-button
// single-cycle event pulses. The events are press, release, long-press and
// auto-repeat, plus a registered copy of the levels.
// Hold timing is counted in ticks of the external timebase, not in clocks.
// The release and repeat outputs are named release_ev / repeat_ev because
// "release" and "repeat" are reserved words in SystemVerilog.
module mbutton_events #(
    parameter int NOB          = 6,
    parameter int CNT_W        = 10,
    parameter int LONG_TICKS   = 500,
    parameter int REPEAT_TICKS = 100,
    parameter bit REPEAT_EN    = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           tick,
    input  logic [NOB-1:0] buttons,
    output logic [NOB-1:0] held,
    output logic [NOB-1:0] press,
    output logic [NOB-1:0] release_ev,
    output logic [NOB-1:0] long_press,
    output logic [NOB-1:0] repeat_ev,
    output logic           any_event
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    // Terminal counts: the pulse fires on the tick that finds the counter here.
    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

    // held_reg doubles as the previous-level register used for release detection.
    logic [NOB-1:0] held_reg;
    logic [NOB-1:0] press_reg;
    logic [NOB-1:0] release_reg;
    logic [NOB-1:0] long_reg;
    logic [NOB-1:0] repeat_reg;
    logic           any_event_reg;

    logic [NOB-1:0] press_next;
    logic [NOB-1:0] release_next;
    logic [NOB-1:0] long_next;
    logic [NOB-1:0] repeat_next;

    genvar gi;
    generate
        for (gi = 0; gi < NOB; gi++) begin : g_btn
            state_t           state_reg;
            state_t           state_next;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_next;
            logic             press_b;
            logic             release_b;
            logic             long_b;
            logic             repeat_b;

            // Per-button state and tick counter register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state_reg <= ST_IDLE;
                    cnt_reg   <= '0;
                end else begin
                    state_reg <= state_next;
                    cnt_reg   <= cnt_next;
                end
            end

            // Next-state and event decode; a low level always wins over tick handling.
            always_comb begin
                state_next = state_reg;
                cnt_next   = cnt_reg;
                press_b    = 1'b0;
                release_b  = 1'b0;
                long_b     = 1'b0;
                repeat_b   = 1'b0;
                if (!buttons[gi]) begin
                    // Release fires only if the button was seen pressed on the previous sample.
                    release_b  = held_reg[gi];
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else begin
                    case (state_reg)
                        ST_IDLE: begin
                            // A tick coinciding with the press is deliberately not counted.
                            press_b    = 1'b1;
                            state_next = ST_HOLD;
                            cnt_next   = '0;
                        end
                        ST_HOLD: begin
                            if (tick) begin
                                if (cnt_reg == LONG_LAST) begin
                                    long_b     = 1'b1;
                                    state_next = ST_REPEAT;
                                    cnt_next   = '0;
                                end else begin
                                    cnt_next = cnt_reg + CNT_W'(1);
                                end
                            end
                        end
                        ST_REPEAT: begin
                            // With repeat disabled this state is parked: the counter is frozen.
                            if (REPEAT_EN && tick) begin
                                if (cnt_reg == REPEAT_LAST) begin
                                    repeat_b = 1'b1;
                                    cnt_next = '0;
                                end else begin
                                    cnt_next = cnt_reg + CNT_W'(1);
                                end
                            end
                        end
                        default: begin
                            state_next = ST_IDLE;
                            cnt_next   = '0;
                        end
                    endcase
                end
            end

            assign press_next[gi]   = press_b;
            assign release_next[gi] = release_b;
            assign long_next[gi]    = long_b;
            assign repeat_next[gi]  = repeat_b;
        end
    endgenerate

    // Output registers: every pulse and the held level appear one clk after sampling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_reg      <= '0;
            press_reg     <= '0;
            release_reg   <= '0;
            long_reg      <= '0;
            repeat_reg    <= '0;
            any_event_reg <= 1'b0;
        end else begin
            held_reg      <= buttons;
            press_reg     <= press_next;
            release_reg   <= release_next;
            long_reg      <= long_next;
            repeat_reg    <= repeat_next;
            any_event_reg <= |(press_next | release_next | long_next | repeat_next);
        end
    end

    assign held       = held_reg;
    assign press      = press_reg;
    assign release_ev = release_reg;
    assign long_press = long_reg;
    assign repeat_ev  = repeat_reg;
    assign any_event  = any_event_reg;

endmodule
